button_event_decoder: RTL and testbench
=======================================

# button_event_decoder

Consumes the debouncer's clean button level and press/release pulses, and classifies each gesture as a short press, double press, long press, or auto-repeat. It sits between the per-button debouncers and the BlackJack game controller, so game logic sees one single-cycle command pulse per gesture instead of raw edges. Runs in the 2 kHz button clock domain.

## Interface
- LONG_TICKS, 1000: hold duration for a long press (500 ms at 2 kHz).
- DOUBLE_TICKS, 500: window after a release in which a second press counts as a double.
- REPEAT_TICKS, 200: auto-repeat period while long-held.
- MIN_TICKS, 20: presses shorter than this are rejected as glitches.
- CNT_W, 11: counter width. Must satisfy 2**CNT_W > every *_TICKS value.

Ports:
- i_Clk_2kHz  in  1  2 kHz button clock. One clock only.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_ButtonDeb  in  1  debounced level. Button is active-low: 1 means released.
- i_ButtonDown  in  1  one-cycle pulse on press (falling edge of the level).
- i_ButtonUp  in  1  one-cycle pulse on release (rising edge of the level).
- o_Short  out  1  one-cycle pulse: short press confirmed.
- o_Double  out  1  one-cycle pulse: double press.
- o_Long  out  1  one-cycle pulse: long-press threshold reached.
- o_Repeat  out  1  one-cycle pulse: auto-repeat tick while long-held.
- o_Held  out  1  level: a press is currently being tracked.
- o_Busy  out  1  level: FSM is not in IDLE.

## Operation
- States: IDLE, PRESSED, WAIT_SECOND, SECOND_PRESSED, LONG_HELD.
- A single counter `cnt` (CNT_W bits, saturating) is cleared on every state change and increments once per cycle otherwise.
- IDLE
  - i_ButtonDown → PRESSED.
  - All other inputs are ignored, including i_ButtonDeb=0 with no Down pulse (for example, the button was held through reset).
- PRESSED
  - i_ButtonUp with cnt < MIN_TICKS → IDLE, no event.
  - i_ButtonUp with cnt ≥ MIN_TICKS → WAIT_SECOND.
  - cnt == LONG_TICKS-1 with no Up → pulse o_Long, go to LONG_HELD.
- WAIT_SECOND
  - i_ButtonDown → SECOND_PRESSED.
  - cnt == DOUBLE_TICKS-1 → pulse o_Short, go to IDLE.
- SECOND_PRESSED
  - i_ButtonUp → pulse o_Double, go to IDLE.
  - Long detection is disabled here; cnt saturates.
- LONG_HELD
  - cnt == REPEAT_TICKS-1 → pulse o_Repeat, clear cnt.
  - i_ButtonUp → IDLE, no event.
- Simultaneous Down and Up in one cycle (not producible by the debouncer): ignored in IDLE; in all other states Up takes priority and Down is dropped.
- At most one event pulse is asserted in any cycle.
- o_Held = 1 in PRESSED, SECOND_PRESSED and LONG_HELD.
- o_Busy = 1 whenever state ≠ IDLE.

## Timing
- All outputs are registered.
- An event pulse asserts the cycle after its triggering condition is sampled and lasts exactly one cycle.
- Reset values: state IDLE, cnt 0, all outputs 0. Reset asserts asynchronously mid-operation, with no pending event emitted.
- Down pulse sampled at cycle 0:
  - o_Held rises at cycle 1.
  - o_Long asserts at cycle LONG_TICKS+1.
  - o_Repeat asserts every REPEAT_TICKS cycles after o_Long.
- Up sampled at cycle u from PRESSED (accepted press): o_Short asserts at u+DOUBLE_TICKS+1, unless a Down arrives first.
- o_Double asserts the cycle after the second Up is sampled.
- Counter saturation at 2**CNT_W-1 must never wrap.

## Structure
- Shared package `button_pkg` holds:
  - the state encoding localparams (3-bit);
  - default tick constants for 2 kHz;
  - so it can be reused by other button-side blocks.
- One natural sub-module: `sat_tick_counter`, a CNT_W-bit counter with clear, enable and saturation.
- The FSM and output registers live in the top module.

## Test plan
All scenarios use LONG=8, DOUBLE=5, REPEAT=3, MIN=2, with Down at cycle 0.
- Short press: Up at cycle 4 → exactly one o_Short at cycle 10; no other pulses; o_Busy low from cycle 10.
- Glitch: Up at cycle 1 (cnt=0) → no event pulse; IDLE at cycle 2; o_Held high only during cycle 1.
- Double press: Up at 4, Down at 7, Up at 9 → one o_Double at cycle 10; no o_Short.
- Long and repeat: hold to cycle 16 → o_Long at 9, o_Repeat at 12 and 15; Up at 16 → IDLE, no further pulses.
- Reset mid-operation: i_Rst_n low at cycle 5 of LONG_HELD → outputs 0 immediately. After reset, i_ButtonDeb=0 with no Down gives no events until a fresh Down/Up cycle, which yields o_Short.

Source files
------------

// File: rtl/button_event_decoder_pkg.sv
// button_pkg: shared state encoding and 2 kHz tick defaults for button-side blocks
package button_pkg;

   localparam logic [2:0] ST_IDLE           = 3'd0;
   localparam logic [2:0] ST_PRESSED        = 3'd1;
   localparam logic [2:0] ST_WAIT_SECOND    = 3'd2;
   localparam logic [2:0] ST_SECOND_PRESSED = 3'd3;
   localparam logic [2:0] ST_LONG_HELD      = 3'd4;

   typedef enum logic [2:0] {
      IDLE           = ST_IDLE,
      PRESSED        = ST_PRESSED,
      WAIT_SECOND    = ST_WAIT_SECOND,
      SECOND_PRESSED = ST_SECOND_PRESSED,
      LONG_HELD      = ST_LONG_HELD
   } state_t;

   localparam int DEF_LONG_TICKS   = 1000;
   localparam int DEF_DOUBLE_TICKS = 500;
   localparam int DEF_REPEAT_TICKS = 200;
   localparam int DEF_MIN_TICKS    = 20;
   localparam int DEF_CNT_W        = 11;

endpackage

// File: rtl/button_event_decoder_if.sv
// button_event_if: debounced button inputs and decoded gesture outputs
interface button_event_if;

   logic i_ButtonDeb;
   logic i_ButtonDown;
   logic i_ButtonUp;
   logic o_Short;
   logic o_Double;
   logic o_Long;
   logic o_Repeat;
   logic o_Held;
   logic o_Busy;

   modport master (
      output i_ButtonDeb, i_ButtonDown, i_ButtonUp,
      input  o_Short, o_Double, o_Long, o_Repeat, o_Held, o_Busy
   );

   modport slave (
      input  i_ButtonDeb, i_ButtonDown, i_ButtonUp,
      output o_Short, o_Double, o_Long, o_Repeat, o_Held, o_Busy
   );

endinterface

// File: rtl/button_event_decoder_sat_tick_counter.sv
// sat_tick_counter: tick counter with synchronous clear, enable and saturation at all-ones
module sat_tick_counter #(
   parameter int CNT_W = 11
) (
   input  logic             i_Clk_2kHz,
   input  logic             i_Rst_n,
   input  logic             i_Clr,
   input  logic             i_En,
   output logic [CNT_W-1:0] o_Cnt
);

   // clear wins over counting; hold at all-ones so long presses never wrap
   always_ff @(posedge i_Clk_2kHz or negedge i_Rst_n)
      if (!i_Rst_n)
         o_Cnt <= '0;
      else
         o_Cnt <= i_Clr ? '0 : (i_En && !(&o_Cnt)) ? o_Cnt + 1'b1 : o_Cnt;

endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: classifies debounced presses into short/double/long/repeat pulses
module button_event_decoder
   import button_pkg::*;
#(
   parameter int LONG_TICKS   = DEF_LONG_TICKS,
   parameter int DOUBLE_TICKS = DEF_DOUBLE_TICKS,
   parameter int REPEAT_TICKS = DEF_REPEAT_TICKS,
   parameter int MIN_TICKS    = DEF_MIN_TICKS,
   parameter int CNT_W        = DEF_CNT_W
) (
   input  logic           i_Clk_2kHz,
   input  logic           i_Rst_n,
   button_event_if.slave  btn
);

   localparam logic [CNT_W-1:0] LONG_END   = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] DOUBLE_END = CNT_W'(DOUBLE_TICKS - 1);
   localparam logic [CNT_W-1:0] REPEAT_END = CNT_W'(REPEAT_TICKS - 1);
   localparam logic [CNT_W-1:0] MIN_CNT    = CNT_W'(MIN_TICKS);

   state_t           state, nextState;
   logic [CNT_W-1:0] cnt;
   logic             evShort, evDouble, evLong, evRepeat;
   logic             cntClr;

   // next-state and event decode; Up beats Down, and a Down wins over the double-window timeout
   always_comb begin
      nextState = state;
      evShort   = 1'b0;
      evDouble  = 1'b0;
      evLong    = 1'b0;
      evRepeat  = 1'b0;
      case (state)
         IDLE:
            if (btn.i_ButtonDown && !btn.i_ButtonUp) nextState = PRESSED;
         PRESSED:
            if (btn.i_ButtonUp) nextState = (cnt < MIN_CNT) ? IDLE : WAIT_SECOND;
            else if (cnt == LONG_END) begin
               evLong    = 1'b1;
               nextState = LONG_HELD;
            end
         WAIT_SECOND:
            if (btn.i_ButtonDown && !btn.i_ButtonUp) nextState = SECOND_PRESSED;
            else if (cnt == DOUBLE_END) begin
               evShort   = 1'b1;
               nextState = IDLE;
            end
         SECOND_PRESSED:
            if (btn.i_ButtonUp) begin
               evDouble  = 1'b1;
               nextState = IDLE;
            end
         LONG_HELD:
            if (btn.i_ButtonUp) nextState = IDLE;
            else evRepeat = (cnt == REPEAT_END);
         default:
            nextState = IDLE;
      endcase
   end

   assign cntClr = (nextState != state) || evRepeat;

   sat_tick_counter #(.CNT_W(CNT_W)) u_cnt (
      .i_Clk_2kHz (i_Clk_2kHz),
      .i_Rst_n    (i_Rst_n),
      .i_Clr      (cntClr),
      .i_En       (state != IDLE),
      .o_Cnt      (cnt)
   );

   // state register plus registered outputs, all derived from the decoded next state
   always_ff @(posedge i_Clk_2kHz or negedge i_Rst_n)
      if (!i_Rst_n) begin
         state        <= IDLE;
         btn.o_Short  <= 1'b0;
         btn.o_Double <= 1'b0;
         btn.o_Long   <= 1'b0;
         btn.o_Repeat <= 1'b0;
         btn.o_Held   <= 1'b0;
         btn.o_Busy   <= 1'b0;
      end else begin
         state        <= nextState;
         btn.o_Short  <= evShort;
         btn.o_Double <= evDouble;
         btn.o_Long   <= evLong;
         btn.o_Repeat <= evRepeat;
         btn.o_Held   <= (nextState == PRESSED) || (nextState == SECOND_PRESSED) || (nextState == LONG_HELD);
         btn.o_Busy   <= (nextState != IDLE);
      end

endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: directed gestures with a pulse scoreboard and level checks
module tb_button_event_decoder;

   localparam int K_SHORT  = 0;
   localparam int K_DOUBLE = 1;
   localparam int K_LONG   = 2;
   localparam int K_REPEAT = 3;

   typedef struct {
      int cyc;
      int kind;
   } ev_t;

   logic     clk;
   logic     rst_n;
   int       edgeCnt;
   int       checks;
   int       errors;
   int       base;
   int       heldLog [64];
   int       busyLog [64];
   ev_t      expQ [$];
   ev_t      e;
   logic [3:0] p;
   string    kindName [4] = '{"short", "double", "long", "repeat"};

   button_event_if bif ();

   button_event_decoder #(
      .LONG_TICKS   (8),
      .DOUBLE_TICKS (5),
      .REPEAT_TICKS (3),
      .MIN_TICKS    (2),
      .CNT_W        (4)
   ) dut (
      .i_Clk_2kHz (clk),
      .i_Rst_n    (rst_n),
      .btn        (bif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial edgeCnt = 0;
   always @(posedge clk) edgeCnt = edgeCnt + 1;

   // monitor: cycle visible at a negedge is edgeCnt+1 in the numbering where Down is sampled at cycle base
   always @(negedge clk) begin
      if (rst_n) begin
         while (expQ.size() > 0 && expQ[0].cyc < edgeCnt + 1) begin
            e = expQ.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_%s got=none required at cycle %0d", kindName[e.kind], e.cyc);
         end
         p = {bif.o_Repeat, bif.o_Long, bif.o_Double, bif.o_Short};
         if (p != 4'b0) begin
            checks++;
            if (!$onehot(p)) begin
               errors++;
               $display("FAIL onehot got=%b required a single pulse at cycle %0d", p, edgeCnt + 1);
            end
            for (int k = 0; k < 4; k++)
               if (p[k]) begin
                  checks++;
                  if (expQ.size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_%s got pulse at cycle %0d required none", kindName[k], edgeCnt + 1);
                  end else begin
                     e = expQ.pop_front();
                     if (e.kind != k || e.cyc != edgeCnt + 1) begin
                        errors++;
                        $display("FAIL event got=%s@%0d required=%s@%0d", kindName[k], edgeCnt + 1, kindName[e.kind], e.cyc);
                     end
                  end
               end
         end
      end
   end

   task automatic chk(input string nm, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s got=%0d required=%0d", nm, got, req);
      end
   endtask

   task automatic want(input int c, input int k);
      ev_t w;
      w.cyc  = c;
      w.kind = k;
      expQ.push_back(w);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic runScen(input int len, input int d0, input int d1, input int u0, input int u1);
      for (int k = 0; k < len; k++) begin
         logic dn, upp;
         dn  = (k == d0) || (k == d1);
         upp = (k == u0) || (k == u1);
         bif.i_ButtonDown = dn;
         bif.i_ButtonUp   = upp;
         if (dn && !upp) bif.i_ButtonDeb = 1'b0;
         else if (upp && !dn) bif.i_ButtonDeb = 1'b1;
         @(posedge clk);
         #1;
         heldLog[k+1] = int'(bif.o_Held);
         busyLog[k+1] = int'(bif.o_Busy);
      end
      bif.i_ButtonDown = 1'b0;
      bif.i_ButtonUp   = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bif.i_ButtonDeb  = 1'b1;
      bif.i_ButtonDown = 1'b0;
      bif.i_ButtonUp   = 1'b0;
      idle(3);
      chk("reset_outputs", int'({bif.o_Short, bif.o_Double, bif.o_Long, bif.o_Repeat, bif.o_Held, bif.o_Busy}), 0);
      rst_n = 1'b1;
      idle(3);

      base = edgeCnt + 1;
      want(base + 10, K_SHORT);
      runScen(12, 0, -1, 4, -1);
      chk("short_held1", heldLog[1], 1);
      chk("short_held5", heldLog[5], 0);
      chk("short_busy9", busyLog[9], 1);
      chk("short_busy10", busyLog[10], 0);
      idle(3);

      runScen(6, 0, -1, 1, -1);
      chk("glitch_held1", heldLog[1], 1);
      chk("glitch_held2", heldLog[2], 0);
      chk("glitch_busy2", busyLog[2], 0);
      idle(3);

      runScen(10, 0, -1, 2, -1);
      chk("min_reject_busy3", busyLog[3], 0);
      idle(3);

      base = edgeCnt + 1;
      want(base + 9, K_SHORT);
      runScen(12, 0, -1, 3, -1);
      idle(3);

      base = edgeCnt + 1;
      want(base + 10, K_DOUBLE);
      runScen(12, 0, 7, 4, 9);
      chk("double_held8", heldLog[8], 1);
      chk("double_held10", heldLog[10], 0);
      idle(3);

      base = edgeCnt + 1;
      want(base + 9, K_LONG);
      want(base + 12, K_REPEAT);
      want(base + 15, K_REPEAT);
      runScen(22, 0, -1, 16, -1);
      chk("long_held16", heldLog[16], 1);
      chk("long_held17", heldLog[17], 0);
      chk("long_busy17", busyLog[17], 0);
      idle(3);

      base = edgeCnt + 1;
      want(base + 10, K_SHORT);
      runScen(12, 0, 4, 4, -1);
      idle(3);

      runScen(6, 0, -1, 0, -1);
      chk("idle_both_busy1", busyLog[1], 0);
      idle(3);

      base = edgeCnt + 1;
      want(base + 48, K_DOUBLE);
      runScen(50, 0, 7, 4, 47);
      chk("sat_held40", heldLog[40], 1);
      chk("sat_busy49", busyLog[49], 0);
      idle(3);

      base = edgeCnt + 1;
      want(base + 9, K_LONG);
      want(base + 12, K_REPEAT);
      runScen(14, 0, -1, -1, -1);
      chk("rst_pre_held", heldLog[14], 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_outputs", int'({bif.o_Short, bif.o_Double, bif.o_Long, bif.o_Repeat, bif.o_Held, bif.o_Busy}), 0);
      idle(2);
      rst_n = 1'b1;
      idle(20);
      chk("rst_deb_low_busy", int'(bif.o_Busy), 0);
      chk("rst_deb_low_held", int'(bif.o_Held), 0);
      runScen(3, -1, -1, 0, -1);
      chk("rst_idle_up_busy", busyLog[3], 0);
      base = edgeCnt + 1;
      want(base + 10, K_SHORT);
      runScen(12, 0, -1, 4, -1);
      idle(5);

      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL pending_events got=%0d outstanding required=0", expQ.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
